parity_frame_tx: RTL and testbench

Serial frame transmitter that sequences the parity generator datapath. Accepts a DATA_W-bit word over a valid/ready handshake and appends the parity bit. Shifts out start bit, data (LSB first), parity bit and stop bit on a single line, each bit held for CLKS_PER_BIT clocks. Sits between a parallel producer and a serial link, one frame in flight at a time.

---
 rtl/parity_frame_tx.sv | 116 +++++++++++
 tb/tb_parity_frame_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit,
// each held CLKS_PER_BIT clocks, with a valid/ready word intake.
module parity_frame_tx #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          ODD          = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic [DATA_W:0]   frame_out
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam int unsigned PRE_LAST = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PRE_LAST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam bit SINGLE_CLK = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic              in_parity;
  logic              bit_end;

  assign shift_nxt = shift >> 1;
  assign in_parity = ODD ? ~(^in_data) : (^in_data);
  assign bit_end   = (bit_cnt == CNT_LAST);
  assign in_ready  = (state == IDLE);

  // Frame sequencer; tx is updated together with the state so it stays registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_out  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift     <= in_data;
            frame_out <= {in_parity, in_data};
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift_nxt;
            if (bit_idx == IDX_LAST) begin
              tx    <= frame_out[DATA_W];
              state <= PARITY;
            end else begin
              tx      <= shift_nxt[0];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx         <= 1'b1;
            frame_done <= SINGLE_CLK;
            state      <= STOP;
          end
        end
        STOP: begin
          // Pulse is raised one edge early so it lands on the final STOP clock.
          if (bit_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            frame_done <= (bit_cnt == CNT_PRE);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: scoreboarded main instance plus even-parity and
// single-clock-per-bit instances checked directly.
module tb_parity_frame_tx;

  localparam int unsigned W      = 4;
  localparam int unsigned C      = 4;
  localparam int unsigned FRAME  = (W + 3) * C;
  localparam int unsigned FFRAME = W + 3;

  typedef struct packed {
    logic [W+2:0] seq;
    logic [W:0]   fo;
    logic         b2b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, tx, busy, frame_done;
  logic [W-1:0] in_data;
  logic [W:0]   frame_out;

  logic         e_valid, e_ready, e_tx, e_busy, e_done;
  logic [W-1:0] e_data;
  logic [W:0]   e_fout;

  logic         f_rst_n, f_valid, f_ready, f_tx, f_busy, f_done;
  logic [W-1:0] f_data;
  logic [W:0]   f_fout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb[$];

  parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(C), .ODD(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done), .frame_out(frame_out)
  );

  parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(C), .ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .in_valid(e_valid), .in_data(e_data),
    .in_ready(e_ready), .tx(e_tx), .busy(e_busy), .frame_done(e_done), .frame_out(e_fout)
  );

  parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(1), .ODD(1'b1)) u_fast (
    .clk(clk), .rst_n(f_rst_n), .in_valid(f_valid), .in_data(f_data),
    .in_ready(f_ready), .tx(f_tx), .busy(f_busy), .frame_done(f_done), .frame_out(f_fout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: captures each frame of the main instance and compares with the scoreboard.
  initial begin : monitor
    int           n;
    int           last_done;
    logic [W+2:0] seq;
    logic [W:0]   fo_hold;
    bit           ready_ok;
    bit           fo_ok;
    exp_t         e;
    last_done = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && busy) begin
        n = 1;
        seq = '0;
        fo_hold = frame_out;
        ready_ok = 1'b1;
        fo_ok = 1'b1;
        forever begin
          if (((n - 1) % C) == (C / 2) && ((n - 1) / C) < (W + 3)) seq[(n - 1) / C] = tx;
          if (in_ready) ready_ok = 1'b0;
          if (frame_out !== fo_hold) fo_ok = 1'b0;
          if (frame_done || n > int'(FRAME) + 4) break;
          @(negedge clk);
          n++;
        end
        if (!frame_done) begin
          check("frame_done_timeout", 32'(frame_done), 32'd1);
        end else begin
          check("frame_len", 32'(n), 32'(FRAME));
          check("in_ready_low_in_frame", 32'(ready_ok), 32'd1);
          check("frame_out_stable", 32'(fo_ok), 32'd1);
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("tx_bits", 32'(seq), 32'(e.seq));
            check("frame_out", 32'(frame_out), 32'(e.fo));
            if (e.b2b) check("done_spacing", 32'(cyc - last_done), 32'(FRAME + 1));
          end
          last_done = cyc;
          @(negedge clk);
          check("done_one_cycle", 32'(frame_done), 32'd0);
          check("ready_after_done", 32'(in_ready), 32'd1);
          check("idle_tx", 32'(tx), 32'd1);
          check("busy_after_done", 32'(busy), 32'd0);
        end
      end else if (rst_n && frame_done) begin
        check("spurious_done", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W+2:0] seq, input logic [W:0] fo,
                      input bit b2b);
    int t;
    sb.push_back('{seq: seq, fo: fo, b2b: b2b});
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic even_frame(input logic [W-1:0] d, output logic [W+2:0] seq,
                            output logic [W:0] fo, output int done_n);
    int t;
    t = 0;
    while (!e_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    e_valid = 1'b1;
    e_data  = d;
    @(negedge clk);
    e_valid = 1'b0;
    e_data  = ~d;
    fo = e_fout;
    seq = '0;
    done_n = 0;
    for (int n = 1; n <= int'(FRAME) + 2; n++) begin
      if (((n - 1) % C) == (C / 2) && ((n - 1) / C) < (W + 3)) seq[(n - 1) / C] = e_tx;
      if (e_done && done_n == 0) done_n = n;
      @(negedge clk);
    end
  endtask

  task automatic fast_frame(input logic [W-1:0] d, output logic [W+2:0] seq,
                            output logic [W:0] fo, output int done_n);
    f_valid = 1'b1;
    f_data  = d;
    @(negedge clk);
    f_valid = 1'b0;
    f_data  = ~d;
    fo = f_fout;
    seq = '0;
    done_n = 0;
    for (int n = 1; n <= int'(FFRAME) + 1; n++) begin
      if (n <= int'(FFRAME)) seq[n - 1] = f_tx;
      if (f_done && done_n == 0) done_n = n;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W+2:0] seq;
    logic [W:0]   fo;
    int           dn;
    bit           seen;

    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'hF;
    e_valid = 1'b1; e_data = 4'hF;
    f_rst_n = 1'b0; f_valid = 1'b1; f_data = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_frame_out", 32'(frame_out), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1; in_valid = 1'b0;
    e_valid = 1'b0; f_valid = 1'b0; f_rst_n = 1'b1;
    @(negedge clk);
    check("no_frame_after_rst", 32'(busy), 32'd0);

    // Nominal odd-parity word, then all zeros.
    send(4'b1011, 7'b1010110, 5'b01011, 1'b0);
    in_valid = 1'b0;
    send(4'b0000, 7'b1100000, 5'b10000, 1'b0);
    in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high.
    send(4'hA, 7'b1110100, 5'b11010, 1'b0);
    send(4'h5, 7'b1101010, 5'b10101, 1'b1);
    in_valid = 1'b0;
    drain();

    // in_data toggles every cycle while the frame is in flight.
    send(4'h3, 7'b1100110, 5'b10011, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < int'(FRAME); i++) begin
      in_data = ~in_data;
      @(posedge clk);
      #1;
    end
    drain();

    // Even parity instance.
    even_frame(4'b0111, seq, fo, dn);
    check("even_0111_frame_out", 32'(fo), 32'b10111);
    check("even_0111_tx_bits", 32'(seq), 32'b1101110);
    even_frame(4'b0000, seq, fo, dn);
    check("even_0000_frame_out", 32'(fo), 32'b00000);
    check("even_0000_tx_bits", 32'(seq), 32'b1000000);
    check("even_done_pos", 32'(dn), 32'(FRAME));

    // One clock per bit, then a reset in the middle of the next frame.
    @(negedge clk);
    fast_frame(4'hF, seq, fo, dn);
    check("fast_frame_out", 32'(fo), 32'b11111);
    check("fast_tx_bits", 32'(seq), 32'b1111110);
    check("fast_done_pos", 32'(dn), 32'(FFRAME));
    check("fast_ready_after", 32'(f_ready), 32'd1);
    f_valid = 1'b1;
    f_data  = 4'h0;
    @(negedge clk);
    f_valid = 1'b0;
    @(negedge clk);
    check("fast_in_data_bit", 32'(f_tx), 32'd0);
    check("fast_busy_mid", 32'(f_busy), 32'd1);
    f_rst_n = 1'b0;
    @(negedge clk);
    f_rst_n = 1'b1;
    check("fast_rst_tx", 32'(f_tx), 32'd1);
    check("fast_rst_ready", 32'(f_ready), 32'd1);
    check("fast_rst_busy", 32'(f_busy), 32'd0);
    check("fast_rst_frame_out", 32'(f_fout), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (f_done) seen = 1'b1;
    end
    check("fast_no_done_after_rst", 32'(seen), 32'd0);

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
